// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal shift register: load, logical/arithmetic shifts, rotates,
// soft clear, plus a saturating count of shift/rotate operations since the last load or clear.
module shift_reg_univ #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero,
  output logic [CNT_W-1:0] shift_cnt
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ASR  = 3'b110,
    M_SCLR = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mode_e            op;
  logic [WIDTH-1:0] q_next;
  logic             cnt_clear;
  logic             cnt_inc;

  assign op = mode_e'(mode);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    q_next    = q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (op)
      M_HOLD: ;
      M_LOAD: begin
        q_next    = d;
        cnt_clear = 1'b1;
      end
      M_SHL: begin
        q_next  = {q[WIDTH-2:0], sin};
        cnt_inc = 1'b1;
      end
      M_SHR: begin
        q_next  = {sin, q[WIDTH-1:1]};
        cnt_inc = 1'b1;
      end
      M_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        cnt_inc = 1'b1;
      end
      M_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        cnt_inc = 1'b1;
      end
      M_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        cnt_inc = 1'b1;
      end
      M_SCLR: begin
        q_next    = RESET_VAL;
        cnt_clear = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, regardless of the order the statements are written in.
  always_ff @(posedge clk) begin
    if (clr) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
    end else if (en) begin
      q <= q_next;
      if (cnt_clear)
        shift_cnt <= '0;
      else if (cnt_inc && shift_cnt != CNT_MAX)
        shift_cnt <= shift_cnt + 1'b1;
    end
  end

  // Serial taps expose the bit the next shift/rotate will push out.
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign zero   = (q == '0);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios with literal
// expectations, then random traffic compared every cycle against an arithmetic model.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = 8'h00;
  logic       sin = 1'b0;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       zero;
  logic [3:0] shift_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model state, plain integers.
  int m_q = 0;
  int m_cnt = 0;

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .zero(zero), .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, actual, expected);
    end
  endtask

  // Model: each mode written as arithmetic on the integer value of q.
  always @(posedge clk) begin
    if (clr) begin
      m_q   = 0;
      m_cnt = 0;
    end else if (en) begin
      case (mode)
        3'd1: begin m_q = int'(d); m_cnt = 0; end
        3'd2: m_q = (m_q * 2) % 256 + int'(sin);
        3'd3: m_q = m_q / 2 + int'(sin) * 128;
        3'd4: m_q = (m_q * 2) % 256 + m_q / 128;
        3'd5: m_q = m_q / 2 + (m_q % 2) * 128;
        3'd6: m_q = m_q / 2 + (m_q / 128) * 128;
        3'd7: begin m_q = 0; m_cnt = 0; end
        default: ;
      endcase
      if (mode >= 3'd2 && mode <= 3'd6 && m_cnt < 15) m_cnt = m_cnt + 1;
    end
  end

  // Compare process: away from the active edge, every cycle once reset is done.
  always @(negedge clk) begin
    if (check_en) begin
      check("q", int'(q), m_q);
      check("shift_cnt", int'(shift_cnt), m_cnt);
      check("sout_l", int'(sout_l), m_q / 128);
      check("sout_r", int'(sout_r), m_q % 2);
      check("zero", int'(zero), int'(m_q == 0));
    end
  end

  task automatic step(input bit c, input bit e, input logic [2:0] m,
                      input logic [7:0] dd, input bit s);
    @(negedge clk);
    #1;
    clr = c; en = e; mode = m; d = dd; sin = s;
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] v);
    step(1'b0, 1'b1, 3'd1, v, 1'b0);
  endtask

  logic prev_sout_r;

  initial begin
    // 1: reset dominates
    step(1'b1, 1'b0, 3'd0, 8'hFF, 1'b0);
    check_en = 1'b1;
    step(1'b1, 1'b0, 3'd0, 8'hFF, 1'b0);
    check("t1_q", int'(q), 'h00);
    check("t1_cnt", int'(shift_cnt), 0);
    check("t1_zero", int'(zero), 1);
    step(1'b1, 1'b1, 3'd1, 8'h3C, 1'b0);
    check("t1_clr_prio", int'(q), 'h00);

    // 2: logical shifts
    load(8'hA5);
    step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1);
    check("t2_shl", int'(q), 'h4B);
    check("t2_shl_cnt", int'(shift_cnt), 1);
    prev_sout_r = sout_r;
    step(1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
    check("t2_shr", int'(q), 'h25);
    check("t2_shr_cnt", int'(shift_cnt), 2);
    check("t2_sout_r_before", int'(prev_sout_r), 1);

    // 3: rotates
    load(8'h81);
    step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0);
    check("t3_rol", int'(q), 'h03);
    load(8'h81);
    step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
    check("t3_ror", int'(q), 'hC0);
    check("t3_zero", int'(zero), 0);

    // 4: arithmetic shift right
    load(8'h90);
    step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
    check("t4_asr1", int'(q), 'hC8);
    step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
    check("t4_asr2", int'(q), 'hE4);
    check("t4_cnt", int'(shift_cnt), 2);

    // 5: enable low holds, then soft clear
    load(8'h5A);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd1, 8'hFF, 1'b1);
    check("t5_hold", int'(q), 'h5A);
    step(1'b0, 1'b1, 3'd7, 8'hFF, 1'b1);
    check("t5_sclr", int'(q), 'h00);
    check("t5_sclr_cnt", int'(shift_cnt), 0);

    // 6: counter saturation
    load(8'h01);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0);
    check("t6_q", int'(q), 'h10);
    check("t6_sat", int'(shift_cnt), 15);
    load(8'h00);
    check("t6_load_cnt", int'(shift_cnt), 0);
    check("t6_zero", int'(zero), 1);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised successor to the single-bit D flip-flop with clear and enable.
- WIDTH-bit universal register with synchronous clear, clock enable and eight operating modes: hold, parallel load, logical shift L/R, rotate L/R, arithmetic shift R, soft clear.
- Tracks the number of shift/rotate operations since the last load or clear.
- Used as the general storage and shifting element in datapath labs (serial converters, multiplier/divider shifters).

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, value loaded into q on clr or soft clear (WIDTH bits).
- CNT_W, 4, width of the shift counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  3  operation select, sampled when en=1.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for logical shifts.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- zero  output  1  1 when q == 0, combinational from q.
- shift_cnt  output  CNT_W  count of shift/rotate operations since the last load or clear.

Behaviour:
- Reset: clk is the single clock; clr is synchronous and active-high.
  - clr=1 at a rising edge sets q=RESET_VAL and shift_cnt=0.
  - clr has priority over en and mode.
  - A clr asserted mid-sequence takes effect at the next edge; no partial operation completes.
- Hold: clr=0, en=0 holds q and shift_cnt regardless of mode, d and sin.
- Modes (clr=0, en=1), evaluated at the rising edge, one-cycle latency (q shows the new value after the edge):
  - 000 hold: q and shift_cnt unchanged.
  - 001 load: q=d; shift_cnt=0.
  - 010 shift left: q={q[WIDTH-2:0], sin}.
  - 011 shift right: q={sin, q[WIDTH-1:1]}.
  - 100 rotate left: q={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q={q[0], q[WIDTH-1:1]}.
  - 110 arithmetic shift right: q={q[WIDTH-1], q[WIDTH-1:1]}; sin is ignored.
  - 111 soft clear: q=RESET_VAL; shift_cnt=0.
- Shift counter:
  - Modes 010–110 increment shift_cnt by 1.
  - At 2^CNT_W-1 it stays there (saturating, no wrap).
  - Hold leaves it unchanged.
- Outputs:
  - sout_l, sout_r and zero derive purely from the current q (no extra latency).
  - The bit shifted out by an operation equals sout_l or sout_r before that edge.
- No X propagation: mode is fully decoded and every encoding is defined.

Test Plan:
1. clr=1 for 2 cycles, en=0, d=8'hFF -> q=8'h00, shift_cnt=0, zero=1; clr=1 with en=1, mode=001, d=8'h3C -> q stays 8'h00.
2. Load d=8'hA5, then mode=010 with sin=1 -> q=8'h4B, shift_cnt=1. Then mode=011 with sin=0 -> q=8'h25, shift_cnt=2, and sout_r before that edge was 1.
3. Load 8'h81, mode=100 -> 8'h03; reload 8'h81, mode=101 -> 8'hC0, zero=0.
4. Load 8'h90, mode=110 twice with sin=0 -> 8'hC8, then 8'hE4, shift_cnt=2.
5. Load 8'h5A, then en=0 with mode=001, d=8'hFF for 3 cycles -> q stays 8'h5A. Then en=1, mode=111 -> q=8'h00, shift_cnt=0.
6. CNT_W=4: load 8'h01, then 20 consecutive mode=100 cycles -> q=8'h10, shift_cnt saturates at 15. Then mode=001, d=8'h00 -> shift_cnt=0, zero=1.
